retry_req_ingress_arb: RTL
==========================

// Module: retry_req_ingress_arb
// PURPOSE
//  Upstream feeder of the Retry engine request port. Collects requests from NUM_SRC source nodes, buffers
//  each in a 2-entry FIFO and arbitrates by QoS with aging and round-robin tie-break. Drives the engine's
//  vld_req_in/rdy_req_in handshake and req_type/qos_type/src_id/payload_in from a registered output stage.
// PARAMETERS
//  NUM_SRC     4   number of source ports (2..16)
//  SRC_NODE_W  4   width of src_id; must satisfy 2**SRC_NODE_W >= NUM_SRC
//  PAYLD_BW    64  request payload width
//  AGE_MAX     15  wait cycles after which a source becomes urgent (1..255, 8-bit saturating counter)
// PORTS
//  clk           in   1                 single clock, rising edge
//  rst           in   1                 asynchronous, active-high reset
//  src_vld       in   NUM_SRC           per-source request valid
//  src_rdy       out  NUM_SRC           per-source ready (registered)
//  src_req_type  in   NUM_SRC           per-source 0: no retry allowed, 1: retry allowed
//  src_qos       in   4*NUM_SRC         per-source QoS, slice [4i+3:4i]; higher value = higher priority
//  src_payload   in   PAYLD_BW*NUM_SRC  per-source payload, slice i
//  vld_req_in    out  1                 request valid to Retry engine
//  rdy_req_in    in   1                 Retry engine ready
//  req_type      out  1                 granted request's req_type
//  qos_type      out  4                 granted request's QoS
//  src_id        out  SRC_NODE_W        index of granted source, zero-extended
//  payload_in    out  PAYLD_BW          granted request's payload
// BEHAVIOUR
//  Reset: all FIFOs empty; src_rdy = all 1s one cycle after rst deasserts (0 while rst high);
//   vld_req_in=0, req_type=0, qos_type=0, src_id=0, payload_in=0; ages=0; rr pointer=0. Reset mid-operation
//   drops all buffered and in-flight (vld_req_in held) requests immediately, no drain.
//  Ingress: beat i accepted on an edge where src_vld[i]&src_rdy[i]; {req_type,qos,payload} written to FIFO i.
//   src_rdy[i] = (count_i < 2), registered from count; push is blocked when full even if a pop occurs that
//   cycle (no comb path from rdy_req_in to src_rdy). Each FIFO is in-order.
//  Output stage: one register. load_en = ~vld_req_in | rdy_req_in. On an edge with load_en and >=1 FIFO head
//   valid, winner head is popped and loaded, vld_req_in=1. Output fire with no candidate -> vld_req_in=0.
//   While vld_req_in & ~rdy_req_in all output fields hold stable. Back-to-back fire every cycle supported.
//  Latency: beat accepted on edge E0 -> earliest vld_req_in high after edge E1 (2 cycles src_vld->vld_req_in).
//  Arbitration (combinational over FIFO heads, evaluated each cycle):
//   1. urgent set = heads with age_i == AGE_MAX; if non-empty, candidates = urgent set.
//   2. else candidates = heads with maximum qos among valid heads.
//   3. among candidates, round-robin: first index at or after rr_ptr (wrapping NUM_SRC-1 -> 0).
//   On load: rr_ptr <= winner+1 mod NUM_SRC; age_winner <= 0.
//  Aging: per source, on each edge where head valid and not popped, age_i <= min(age_i+1, AGE_MAX); empty
//   FIFO -> age_i <= 0. Age not incremented for the winner on its load edge.
//  req_type does not affect priority; passed through unchanged.
//  Simultaneous: push and pop of same FIFO on one edge -> count unchanged, order preserved. Single source
//   with FIFO at count 1 streams at full rate only if pushes are accepted (count<2), i.e. steady 1/cycle.
// TESTING
//  1. Reset: rst high mid-stream with vld_req_in=1 held -> all outputs 0, src_rdy=0; after release src_rdy=4'hF.
//  2. Latency/order: src2 sends qos=3 payload 0xA,0xB,0xC back-to-back, rdy_req_in=1 -> vld_req_in high 2 cycles
//     after first accept, outputs A,B,C on consecutive cycles, src_id=2.
//  3. QoS: src0 qos=1, src3 qos=7 same cycle -> src3 granted first, then src0.
//  4. RR tie: all 4 sources qos=5 continuously, rdy_req_in=1 -> grant order 0,1,2,3,0,... each 1/cycle.
//  5. Backpressure: rdy_req_in=0 for 10 cycles -> output fields stable, each src_rdy drops after 2 accepts
//     (FIFO full); release -> no loss, no duplication.
//  6. Aging: AGE_MAX=3, src1 qos=0 vs src0 qos=15 streaming -> src1 granted after waiting exactly 3 cycles.

Source files
------------

// File: rtl/retry_req_ingress_arb.sv
// ---------------------------------------------------------------------------
// retry_req_ingress_arb
//
// Feeds the Retry engine request port from NUM_SRC source nodes. Each source
// owns a 2-entry in-order FIFO. The FIFO heads are arbitrated every cycle:
// sources that have waited AGE_MAX cycles are served first, then the highest
// QoS. Ties are broken round-robin. The winner is popped into a single
// registered output stage that drives the engine's valid/ready handshake.
//
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   src_vld       : per-source request valid
//   src_rdy       : per-source ready, registered from the FIFO fill level
//   src_req_type  : per-source request type (passed through, no priority role)
//   src_qos       : per-source QoS, slice [4i+3:4i], larger = more urgent
//   src_payload   : per-source payload, slice [PAYLD_BW*i +: PAYLD_BW]
//   vld_req_in    : request valid towards the Retry engine
//   rdy_req_in    : Retry engine ready
//   req_type      : granted request type
//   qos_type      : granted request QoS
//   src_id        : index of the granted source, zero-extended
//   payload_in    : granted request payload
// ---------------------------------------------------------------------------
module retry_req_ingress_arb #(
    parameter int NUM_SRC    = 4,
    parameter int SRC_NODE_W = 4,
    parameter int PAYLD_BW   = 64,
    parameter int AGE_MAX    = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_vld,
    output logic [NUM_SRC-1:0]           src_rdy,
    input  logic [NUM_SRC-1:0]           src_req_type,
    input  logic [4*NUM_SRC-1:0]         src_qos,
    input  logic [PAYLD_BW*NUM_SRC-1:0]  src_payload,
    output logic                         vld_req_in,
    input  logic                         rdy_req_in,
    output logic                         req_type,
    output logic [3:0]                   qos_type,
    output logic [SRC_NODE_W-1:0]        src_id,
    output logic [PAYLD_BW-1:0]          payload_in
);

    localparam int              PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    // FIFO entry layout: {req_type, qos[3:0], payload}
    localparam int              ENT_W     = PAYLD_BW + 5;
    localparam logic [7:0]      AGE_LIM   = 8'(AGE_MAX);
    localparam logic [PTR_W:0]  NUM_SRC_W = (PTR_W + 1)'(NUM_SRC);

    logic [NUM_SRC-1:0]       head_vld;
    logic [NUM_SRC-1:0]       urgent;
    logic [NUM_SRC-1:0]       pop;
    logic [NUM_SRC*ENT_W-1:0] head_flat;

    logic                     load_en;
    logic                     found;
    logic [PTR_W-1:0]         win_idx;
    logic [ENT_W-1:0]         win_data;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;

    logic                     vld_q, vld_d;
    logic                     req_type_q, req_type_d;
    logic [3:0]               qos_q, qos_d;
    logic [SRC_NODE_W-1:0]    src_id_q, src_id_d;
    logic [PAYLD_BW-1:0]      payload_q, payload_d;

    // The output register may take a new request whenever it is empty or
    // being consumed this cycle.
    assign load_en = ~vld_q | rdy_req_in;

    // -----------------------------------------------------------------------
    // Per-source 2-entry FIFO and age counter
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [ENT_W-1:0] mem_q [2];
        logic [1:0]       count_q, count_d;
        logic             rd_ptr_q, wr_ptr_q;
        logic             rdy_q;
        logic [7:0]       age_q;
        logic             push;
        logic [ENT_W-1:0] wr_data;

        // rdy_q mirrors count_q < 2 from the previous edge, so a full FIFO
        // refuses a push even when it is popped on the same edge.
        assign push    = src_vld[gi] & rdy_q;
        assign wr_data = {src_req_type[gi], src_qos[4*gi +: 4],
                          src_payload[PAYLD_BW*gi +: PAYLD_BW]};

        assign head_vld[gi]                   = (count_q != 2'd0);
        assign head_flat[ENT_W*gi +: ENT_W]   = mem_q[rd_ptr_q];
        assign urgent[gi]                     = head_vld[gi] & (age_q == AGE_LIM);
        assign pop[gi]                        = load_en & found & (win_idx == PTR_W'(gi));
        assign src_rdy[gi]                    = rdy_q;

        always_comb begin
            count_d = count_q;
            case ({push, pop[gi]})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        // Storage carries no reset; validity is tracked by count_q alone.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_q  <= 2'd0;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                rdy_q    <= 1'b0;
                age_q    <= 8'd0;
            end else begin
                count_q <= count_d;
                rdy_q   <= (count_d != 2'd2);
                if (push) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (pop[gi]) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                // A freshly exposed head (after a pop or a push into an empty
                // FIFO) starts waiting from zero.
                if (!head_vld[gi] || pop[gi]) begin
                    age_q <= 8'd0;
                end else if (age_q != AGE_LIM) begin
                    age_q <= age_q + 8'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration over FIFO heads
    // -----------------------------------------------------------------------
    logic [3:0]             max_qos;
    logic [NUM_SRC-1:0]     qos_cand;
    logic [NUM_SRC-1:0]     cand;
    logic [2*NUM_SRC-1:0]   cand_dbl;
    logic [NUM_SRC-1:0]     cand_rot;
    logic [PTR_W-1:0]       rot_off;
    logic [PTR_W:0]         win_sum;

    always_comb begin
        max_qos = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (head_vld[i] && (head_flat[ENT_W*i + PAYLD_BW +: 4] > max_qos)) begin
                max_qos = head_flat[ENT_W*i + PAYLD_BW +: 4];
            end
        end

        qos_cand = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            qos_cand[i] = head_vld[i] & (head_flat[ENT_W*i + PAYLD_BW +: 4] == max_qos);
        end

        cand = (|urgent) ? urgent : qos_cand;

        // Rotate so bit 0 corresponds to rr_ptr, then take the first set bit;
        // the offset is added back modulo NUM_SRC.
        cand_dbl = {cand, cand} >> rr_ptr_q;
        cand_rot = cand_dbl[NUM_SRC-1:0];

        found   = 1'b0;
        rot_off = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && cand_rot[k]) begin
                found   = 1'b1;
                rot_off = PTR_W'(k);
            end
        end

        win_sum = {1'b0, rr_ptr_q} + {1'b0, rot_off};
        if (win_sum >= NUM_SRC_W) begin
            win_sum = win_sum - NUM_SRC_W;
        end
        win_idx = win_sum[PTR_W-1:0];
    end

    // -----------------------------------------------------------------------
    // Output stage next state
    // -----------------------------------------------------------------------
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_data = head_flat[ENT_W*i +: ENT_W];
            end
        end

        vld_d      = vld_q;
        req_type_d = req_type_q;
        qos_d      = qos_q;
        src_id_d   = src_id_q;
        payload_d  = payload_q;
        rr_ptr_d   = rr_ptr_q;

        if (load_en) begin
            vld_d = found;
            if (found) begin
                req_type_d = win_data[ENT_W-1];
                qos_d      = win_data[PAYLD_BW +: 4];
                src_id_d   = SRC_NODE_W'(win_idx);
                payload_d  = win_data[PAYLD_BW-1:0];
                rr_ptr_d   = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= 1'b0;
            req_type_q <= 1'b0;
            qos_q      <= 4'd0;
            src_id_q   <= '0;
            payload_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            vld_q      <= vld_d;
            req_type_q <= req_type_d;
            qos_q      <= qos_d;
            src_id_q   <= src_id_d;
            payload_q  <= payload_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign vld_req_in = vld_q;
    assign req_type   = req_type_q;
    assign qos_type   = qos_q;
    assign src_id     = src_id_q;
    assign payload_in = payload_q;

endmodule
